// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants for the byte-serial SubBytes engine.
package aes_pkg;

  localparam int NBYTES_DEF = 16;
  localparam int IDX_W      = $clog2(NBYTES_DEF);

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sbox_m.sv
// Forward AES S-box, purely combinational table lookup (row-major, entry 0x00 first).
module sbox_m
  import aes_pkg::*;
(
  input  byte_t in_i,
  output byte_t out_o
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_hi;

  assign bit_hi = 11'd2047 - {in_i, 3'b000};
  assign out_o  = SBOX_TABLE[bit_hi -: 8];

endmodule

// File: rtl/sub_bytes_serial.sv
// Byte-serial AES SubBytes: one S-box shared across the block, one byte per cycle.
// Define SBOX_REG_EN to register the S-box output (adds a DRAIN state, +1 cycle latency).
module sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                busy
);

  localparam int            IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  byte_t         src_q [NBYTES];
  byte_t         res_q [NBYTES];
  byte_t         sbox_in;
  byte_t         sbox_out;

  assign sbox_in = src_q[idx_q];

  sbox_m u_sbox (
    .in_i  (sbox_in),
    .out_o (sbox_out)
  );

`ifdef SBOX_REG_EN
  byte_t         sbox_q;
  logic [IW-1:0] widx_q;
  logic          wr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      for (int i = 0; i < NBYTES; i++) begin
        src_q[i] <= '0;
        res_q[i] <= '0;
      end
`ifdef SBOX_REG_EN
      sbox_q <= '0;
      widx_q <= '0;
      wr_q   <= 1'b0;
`endif
    end else begin
`ifdef SBOX_REG_EN
      // Lookup in RUN, commit one edge later; the last commit happens in DRAIN.
      wr_q   <= (state_q == S_RUN);
      sbox_q <= sbox_out;
      widx_q <= idx_q;
      if (wr_q) res_q[widx_q] <= sbox_q;
`endif
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NBYTES; i++) src_q[i] <= in_data[8*(NBYTES-1-i) +: 8];
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
`ifndef SBOX_REG_EN
          res_q[idx_q] <= sbox_out;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef SBOX_REG_EN
            state_q <= S_DRAIN;
`else
            state_q <= S_DONE;
`endif
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DRAIN: state_q <= S_DONE;
        S_DONE:  if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NBYTES; i++) out_data[8*(NBYTES-1-i) +: 8] = res_q[i];
  end

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Bench for sub_bytes_serial; reference S-box derived from GF(2^8) inverse + affine map.
module tb_sub_bytes_serial;

`ifdef SBOX_REG_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [7:0]   sbox_t [256];
  time          t_acc;

  always #5 clk = ~clk;

  sub_bytes_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] model_sb(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_t[d[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Leaves in_valid high; returns one ns after the accepting edge.
  task automatic do_accept(input logic [127:0] d, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check_eq("accept_timeout", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    t_acc = $time;
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) check_eq("valid_timeout", {127'd0, out_valid}, 128'd1);
  endtask

  task automatic take(output logic [127:0] d);
    d = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int           w, c;
    logic [127:0] a, b, got, hold;
    time          t0;

    build_sbox();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready",  {127'd0, in_ready},  128'd1);
    check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("rst_busy",      {127'd0, busy},      128'd0);
    check_eq("rst_out_data",  out_data,            128'd0);

    // Known vector and latency
    do_accept(128'h00112233445566778899aabbccddeeff, w);
    in_valid = 1'b0;
    check_eq("run_busy", {127'd0, busy}, 128'd1);
    wait_valid(c);
    check_eq("latency", 128'(c), 128'(LAT));
    take(got);
    check_eq("vec_fips", got, 128'h638293c31bfc33f5c4eeacea4bc12816);

    // Back-to-back all-00 then all-ff, in_valid and out_ready held high
    out_ready = 1'b1;
    do_accept({16{8'h00}}, w);
    t0 = t_acc;
    in_data = {16{8'hff}};
    wait_valid(c);
    check_eq("b2b_zero", out_data, {16{8'h63}});
    do_accept({16{8'hff}}, w);
    check_eq("b2b_period", 128'((t_acc - t0) / 10), 128'(LAT + 2));
    in_valid = 1'b0;
    wait_valid(c);
    check_eq("b2b_ff", out_data, {16{8'h16}});
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Backpressure in DONE; in_valid with new data must be ignored
    a = rnd128();
    do_accept(a, w);
    in_valid = 1'b0;
    wait_valid(c);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = rnd128();
      check_eq("bp_out_valid", {127'd0, out_valid}, 128'd1);
      check_eq("bp_out_data",  out_data, model_sb(a));
      check_eq("bp_in_ready",  {127'd0, in_ready}, 128'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_idle_valid", {127'd0, out_valid}, 128'd0);
    check_eq("bp_idle_ready", {127'd0, in_ready},  128'd1);
    @(posedge clk); #1;
    check_eq("bp_no_accept",  {127'd0, busy},      128'd0);

    // Asynchronous reset in the middle of RUN
    do_accept(rnd128(), w);
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("arst_out_data",  out_data, 128'd0);
    check_eq("arst_busy",      {127'd0, busy}, 128'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("arst_in_ready", {127'd0, in_ready}, 128'd1);
    do_accept(128'h00112233445566778899aabbccddeeff, w);
    in_valid = 1'b0;
    wait_valid(c);
    take(got);
    check_eq("arst_fresh", got, 128'h638293c31bfc33f5c4eeacea4bc12816);

    // in_valid held with changing in_data while busy
    a = rnd128();
    do_accept(a, w);
    for (int k = 0; k < LAT - 1; k++) begin
      in_data = rnd128();
      @(posedge clk); #1;
    end
    wait_valid(c);
    check_eq("busy_first", out_data, model_sb(a));
    b = rnd128();
    out_ready = 1'b1;
    do_accept(b, w);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check_eq("busy_wait", 128'(w), 128'd1);
    wait_valid(c);
    take(got);
    check_eq("busy_second", got, model_sb(b));

    // Random blocks with random downstream backpressure
    for (int n = 0; n < 500; n++) begin
      a = rnd128();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      do_accept(a, w);
      in_valid = 1'b0;
      wait_valid(c);
      hold = out_data;
      for (int g = 0; g < 100; g++) begin
        if ($urandom_range(0, 1) == 1) break;
        @(posedge clk); #1;
      end
      if (out_data !== hold) check_eq("rnd_stable", out_data, hold);
      take(got);
      check_eq("rnd_block", got, model_sb(a));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_bytes_serial.md
# sub_bytes_serial

Byte-serial AES SubBytes engine: accepts a 128-bit state block over a valid/ready handshake and substitutes it one byte per cycle through a single S-box lookup. It writes the result into an output register and presents the substituted block downstream over a second valid/ready handshake. It sits between the UART-fed block assembler and the ShiftRows/MixColumns stages, trading 16 cycles of latency for one S-box instance instead of sixteen.

## Interface
- NBYTES, 16: bytes per block; block width is 8*NBYTES.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream block present.
- in_ready  out  1  engine can accept a block.
- in_data  in  8*NBYTES  input state; byte 0 = bits [8*NBYTES-1 -: 8] (MSB-first, transmission order).
- out_valid  out  1  substituted block available.
- out_ready  in  1  downstream accepts block.
- out_data  out  8*NBYTES  substituted state, same byte order.
- busy  out  1  high in RUN (and DRAIN when configured).

## Operation
- States: IDLE, RUN, (DRAIN only with SBOX_REG_EN), DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the source register, clear idx to 0, and go to RUN.
- RUN: each cycle, S-box lookup of source byte idx; result written to out_data byte idx (or to the pipeline register, see Configuration). idx increments by 1. When idx==NBYTES-1, the last byte is written and the state goes to DONE (DRAIN when configured). idx never wraps past NBYTES-1.
- DONE: out_valid=1, out_data stable. On out_valid&&out_ready, go to IDLE. out_data holds its value until the next block overwrites bytes.
- in_ready is 0 outside IDLE. in_valid in RUN/DONE is ignored; in_data is not sampled.
- No concurrent accept and emit: the DONE→IDLE handshake and the next accept are on separate edges.
- Reset (any state, including mid-RUN): state=IDLE, idx=0, out_valid=0, busy=0, in_ready=1 after release, out_data=0, source register=0. A partially substituted block is discarded.

## Timing
- Accept on edge E0. Byte k is written on edge E0+1+k. out_valid rises after edge E0+NBYTES (16 cycles for the default).
- With SBOX_REG_EN, each edge is one later: out_valid rises after E0+NBYTES+1.
- Minimum block period: NBYTES+2 cycles (default 18; 19 with SBOX_REG_EN) when out_ready is held high and in_valid is held high.
- Combinational paths: none from in_valid/out_ready to in_ready/out_valid. All outputs are registered or decoded from state only.

## Configuration
- SBOX_REG_EN defined: the S-box output passes through an 8-bit register with a registered byte index. A DRAIN state (one cycle) follows RUN and commits the final byte. Latency is +1 cycle, and the S-box is off the write path for timing.
- SBOX_REG_EN undefined: the S-box output is written directly to out_data in the same cycle as the lookup. There is no DRAIN state and RUN goes directly to DONE.

## Structure
- Shared package aes_pkg: NBYTES default constant, byte typedef (8-bit), state enum (IDLE, RUN, DRAIN, DONE), and index width $clog2(NBYTES).
- One sub-module: the existing forward S-box module sbox_m, instantiated once. Its input is the byte multiplexed by idx from the source register.

## Test plan
- in_data=00112233445566778899aabbccddeeff, out_ready=1 -> out_data=638293c31bfc33f5c4eeacea4bc12816, and out_valid rises exactly 16 cycles after accept (17 with SBOX_REG_EN).
- in_data all 00 -> out_data all 63. Then in_data all ff -> out_data all 16, sent back-to-back with an 18-cycle period.
- out_ready held low 5 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready stays 0, and in_valid with new data is ignored. Handshake on cycle 6 -> IDLE.
- rst_n pulsed low at RUN byte 7 -> out_valid=0 and out_data=0 immediately (async). After release, in_ready=1 and a fresh block 00..ff gives the correct result.
- in_valid asserted while busy with a changing in_data -> the first block's result is unaffected. The second block is accepted only after out handshake plus one IDLE cycle.
- Random 500 blocks with a random out_ready duty vs. a software SubBytes model -> zero mismatches. Checked in both macro settings.
